bus_client: RTL and testbench

BUS_CLIENT -- requirements
Module: bus_client

---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_client.sv | 157 +++++++++++++++
 tb/tb_bus_client.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: widths, direction encodings and the bus_client state type.
package bus_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RDWAIT,
        RESP
    } bus_client_state_t;

endpackage

// File: rtl/bus_client.sv
// Single-command bus master: latches a core command, requests the arbiter, completes with a one-cycle response.
// Optional request timeout enabled by defining BUS_CLIENT_TIMEOUT_EN.
module bus_client
    import bus_pkg::*;
#(
    parameter int READ_LAT = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_request,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_data_out,
    output logic              bus_rw,
    input  logic [DATA_W-1:0] bus_data_in
);

    if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_read_lat
        $error("bus_client: READ_LAT must be in 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("bus_client: TIMEOUT must be in 1..255");
    end

    localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

    bus_client_state_t state_q;
    logic [3:0]        lat_q;
    logic              bus_request_q;
    logic              rsp_valid_q;
    logic              bus_rw_q;
    logic [ADDR_W-1:0] bus_address_q;
    logic [DATA_W-1:0] bus_data_out_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              timeout_hit;

`ifdef BUS_CLIENT_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic       rsp_err_q;

    // wait_d is the count including the current grant-less REQ cycle.
    assign wait_d      = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    assign timeout_hit = (wait_d >= TIMEOUT_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) wait_q <= '0;
                end
                REQ: begin
                    if (bus_grant) begin
                        if (bus_rw_q == RW_WRITE) rsp_err_q <= 1'b0;
                    end else begin
                        wait_q <= wait_d;
                        if (timeout_hit) rsp_err_q <= 1'b1;
                    end
                end
                RDWAIT: begin
                    if (lat_q == '0) rsp_err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            lat_q          <= '0;
            bus_request_q  <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            bus_rw_q       <= RW_READ;
            bus_address_q  <= '0;
            bus_data_out_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        bus_rw_q       <= cmd_rw;
                        bus_address_q  <= cmd_addr;
                        bus_data_out_q <= cmd_wdata;
                        bus_request_q  <= 1'b1;
                        state_q        <= REQ;
                    end
                end
                REQ: begin
                    // A grant wins over a timeout reached in the same cycle.
                    if (bus_grant) begin
                        bus_request_q <= 1'b0;
                        if (bus_rw_q == RW_WRITE) begin
                            rsp_rdata_q <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            lat_q   <= LAT_INIT;
                            state_q <= RDWAIT;
                        end
                    end else if (timeout_hit) begin
                        bus_request_q <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RDWAIT: begin
                    if (lat_q == '0) begin
                        rsp_rdata_q <= bus_data_in;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign bus_request  = bus_request_q;
    assign bus_address  = bus_address_q;
    assign bus_data_out = bus_data_out_q;
    assign bus_rw       = bus_rw_q;

endmodule

// File: tb/tb_bus_client.sv
// Self-checking bench for bus_client: directed corner cases plus randomized commands against a transaction model.
// Honours BUS_CLIENT_TIMEOUT_EN when deciding whether long grant delays should time out.
module tb_bus_client;

    localparam int READ_LAT = 2;
    localparam int TIMEOUT  = 10;
`ifdef BUS_CLIENT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [8:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       bus_request;
    logic       bus_grant = 1'b0;
    logic [8:0] bus_address;
    logic [7:0] bus_data_out;
    logic       bus_rw;
    logic [7:0] bus_data_in = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_client #(
        .READ_LAT(READ_LAT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .bus_request (bus_request),
        .bus_grant   (bus_grant),
        .bus_address (bus_address),
        .bus_data_out(bus_data_out),
        .bus_rw      (bus_rw),
        .bus_data_in (bus_data_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Idle for n cycles, optionally pulsing a grant nobody asked for.
    task automatic idle_cycles(input int n, input logic g);
        for (int i = 0; i < n; i++) begin
            check("idle_rsp_valid", rsp_valid, 1'b0);
            check("idle_cmd_ready", cmd_ready, 1'b1);
            check("idle_bus_request", bus_request, 1'b0);
            bus_grant = g;
            @(negedge clk);
        end
        bus_grant = 1'b0;
    endtask

    // One full command, starting at a negedge with the DUT idle and ending at the negedge after the response.
    // delay = grant-less REQ cycles before the grant; sdata >= 0 forces the value in the sampling cycle.
    task automatic txn(input logic rw, input logic [8:0] addr, input logic [7:0] wd,
                       input int delay, input int sdata,
                       input logic nv, input logic nrw, input logic [8:0] naddr, input logic [7:0] nwd);
        bit         timed_out;
        int         exp_req;
        int         exp_off;
        int         req_cnt;
        int         off;
        logic       got;
        logic [7:0] d;
        logic [7:0] samp;
        logic [7:0] exp_rd;

        timed_out = TO_EN && (delay >= TIMEOUT);
        exp_req   = timed_out ? TIMEOUT : delay + 1;
        exp_off   = (!timed_out && rw == 1'b0) ? READ_LAT + 1 : 1;

        check("accept_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = nv;
        cmd_rw    = nrw;
        cmd_addr  = naddr;
        cmd_wdata = nwd;

        req_cnt = 0;
        while (bus_request === 1'b1 && req_cnt < 300) begin
            req_cnt++;
            check("req_addr", bus_address, addr);
            check("req_rw", bus_rw, rw);
            check("req_wdata", bus_data_out, wd);
            check("req_ready", cmd_ready, 1'b0);
            bus_grant   = (req_cnt == delay + 1);
            bus_data_in = 8'($urandom);
            @(negedge clk);
        end
        bus_grant = 1'b0;
        check("req_cycles", req_cnt, exp_req);

        off  = 1;
        got  = 1'b0;
        samp = '0;
        while (!got && off < 40) begin
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                check("wait_ready", cmd_ready, 1'b0);
                check("wait_addr", bus_address, addr);
                check("wait_request", bus_request, 1'b0);
                d = (off == READ_LAT && sdata >= 0) ? 8'(sdata) : 8'($urandom);
                if (off == READ_LAT) samp = d;
                bus_data_in = d;
                bus_grant   = 1'($urandom_range(0, 1));
                @(negedge clk);
                off++;
            end
        end
        bus_grant = 1'b0;

        exp_rd = (!timed_out && rw == 1'b0) ? samp : 8'h00;
        check("rsp_seen", got, 1'b1);
        check("rsp_offset", off, exp_off);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", rsp_err, timed_out);
        check("rsp_ready", cmd_ready, 1'b0);
        check("rsp_addr", bus_address, addr);
        @(negedge clk);
        check("post_valid", rsp_valid, 1'b0);
        check("post_rdata", rsp_rdata, exp_rd);
        check("post_err", rsp_err, timed_out);
        check("post_ready", cmd_ready, 1'b1);
    endtask

    // A read is granted at once, then reset lands while it waits for data.
    task automatic reset_in_rdwait();
        check("rr_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 9'h0C7;
        cmd_wdata = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rr_request", bus_request, 1'b1);
        bus_grant = 1'b1;
        @(negedge clk);
        bus_grant = 1'b0;
        check("rr_rdwait_request", bus_request, 1'b0);
        check("rr_rdwait_ready", cmd_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rr_after_ready", cmd_ready, 1'b1);
        check("rr_after_valid", rsp_valid, 1'b0);
        check("rr_after_request", bus_request, 1'b0);
        check("rr_after_address", bus_address, 9'h000);
        check("rr_after_rdata", rsp_rdata, 8'h00);
        repeat (4) begin
            bus_data_in = 8'($urandom);
            @(negedge clk);
            check("rr_no_rsp", rsp_valid, 1'b0);
            check("rr_idle_ready", cmd_ready, 1'b1);
        end
    endtask

    initial begin
        logic       r_rw;
        logic [8:0] r_addr;
        logic [7:0] r_wd;
        logic       n_rw;
        logic [8:0] n_addr;
        logic [7:0] n_wd;
        logic       hold;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_bus_request", bus_request, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 8'h00);
        check("reset_bus_rw", bus_rw, 1'b0);
        check("reset_bus_address", bus_address, 9'h000);
        check("reset_bus_data_out", bus_data_out, 8'h00);

        idle_cycles(3, 1'b1);

        txn(1'b1, 9'h1F3, 8'h5A, 3, -1, 1'b0, 1'b0, 9'h000, 8'h00);
        txn(1'b0, 9'h004, 8'h00, 0, 8'hC3, 1'b0, 1'b0, 9'h000, 8'h00);
        txn(1'b0, 9'h0AA, 8'h11, TIMEOUT - 1, -1, 1'b0, 1'b0, 9'h000, 8'h00);
        txn(1'b1, 9'h155, 8'hEE, TIMEOUT + 10, -1, 1'b0, 1'b0, 9'h000, 8'h00);
        txn(1'b0, 9'h09C, 8'h77, TIMEOUT + 3, -1, 1'b0, 1'b0, 9'h000, 8'h00);

        reset_in_rdwait();
        txn(1'b0, 9'h123, 8'h00, 2, -1, 1'b0, 1'b0, 9'h000, 8'h00);

        txn(1'b1, 9'h0F0, 8'hA5, 1, -1, 1'b1, 1'b0, 9'h10F, 8'h3C);
        txn(1'b0, 9'h10F, 8'h3C, 0, -1, 1'b0, 1'b0, 9'h000, 8'h00);

        idle_cycles(2, 1'b1);

        r_rw   = 1'($urandom);
        r_addr = 9'($urandom);
        r_wd   = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            n_rw   = 1'($urandom);
            n_addr = 9'($urandom);
            n_wd   = 8'($urandom);
            hold   = (i != 39) && 1'($urandom_range(0, 1));
            txn(r_rw, r_addr, r_wd, $urandom_range(0, 14), -1, hold, n_rw, n_addr, n_wd);
            r_rw   = n_rw;
            r_addr = n_addr;
            r_wd   = n_wd;
        end

        idle_cycles(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
